// File: rtl/lib_cpu.sv
// lib_cpu: shared CPU-wide types for the RV32I core.
//   OPECODE    - decoded operation enumerant; LUI is encoding 0, which is the
//                value the decode stage presents out of reset.
//   OPC_*      - major opcode values of instr[6:0].
//   DECODED    - one decoded instruction as it moves between decode and execute.
package lib_cpu;

  typedef enum logic [31:0] {
    LUI = 32'd0, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, FENCE_I,
    ECALL, EBREAK,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
  } OPECODE;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // ECALL and EBREAK are recognised only as these exact words.
  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef struct packed {
    OPECODE      op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } DECODED;

endpackage

// File: rtl/rv32i_decoder.sv
// rv32i_decoder: purely combinational RV32I + Zicsr + Zifencei decoder.
//   instr - raw 32-bit instruction word
//   pc    - PC of instr, passed through into the result
//   dec   - decoded operation, register indices, immediate, pc, illegal flag
// Register fields a format does not carry are forced to 0. Illegal words decode
// as ADDI with no registers and the raw word as immediate (mtval source).
module rv32i_decoder
  import lib_cpu::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output DECODED      dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm_sh;

  OPECODE      op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        legal;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign f_rd  = instr[11:7];
  assign f_rs1 = instr[19:15];
  assign f_rs2 = instr[24:20];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_z  = {20'b0, instr[31:20]};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    op    = ADDI;
    rd    = '0;
    rs1   = '0;
    rs2   = '0;
    imm   = '0;
    legal = 1'b1;
    case (opc)
      OPC_LUI:   begin op = LUI;   rd = f_rd; imm = imm_u; end
      OPC_AUIPC: begin op = AUIPC; rd = f_rd; imm = imm_u; end
      OPC_JAL:   begin op = JAL;   rd = f_rd; imm = imm_j; end
      OPC_JALR: begin
        op = JALR; rd = f_rd; rs1 = f_rs1; imm = imm_i;
        legal = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        rs1 = f_rs1; rs2 = f_rs2; imm = imm_b;
        case (f3)
          3'b000:  op = BEQ;
          3'b001:  op = BNE;
          3'b100:  op = BLT;
          3'b101:  op = BGE;
          3'b110:  op = BLTU;
          3'b111:  op = BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        rd = f_rd; rs1 = f_rs1; imm = imm_i;
        case (f3)
          3'b000:  op = LB;
          3'b001:  op = LH;
          3'b010:  op = LW;
          3'b100:  op = LBU;
          3'b101:  op = LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        rs1 = f_rs1; rs2 = f_rs2; imm = imm_s;
        case (f3)
          3'b000:  op = SB;
          3'b001:  op = SH;
          3'b010:  op = SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        rd = f_rd; rs1 = f_rs1; imm = imm_i;
        case (f3)
          3'b000: op = ADDI;
          3'b010: op = SLTI;
          3'b011: op = SLTIU;
          3'b100: op = XORI;
          3'b110: op = ORI;
          3'b111: op = ANDI;
          3'b001: begin
            op = SLLI; imm = imm_sh;
            legal = (f7 == 7'b0000000);
          end
          default: begin
            imm = imm_sh;
            if (f7 == 7'b0000000)      op = SRLI;
            else if (f7 == 7'b0100000) op = SRAI;
            else                       legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
        case ({f7, f3})
          {7'b0000000, 3'b000}: op = ADD;
          {7'b0000000, 3'b001}: op = SLL;
          {7'b0000000, 3'b010}: op = SLT;
          {7'b0000000, 3'b011}: op = SLTU;
          {7'b0000000, 3'b100}: op = XOR;
          {7'b0000000, 3'b101}: op = SRL;
          {7'b0000000, 3'b110}: op = OR;
          {7'b0000000, 3'b111}: op = AND;
          {7'b0100000, 3'b000}: op = SUB;
          {7'b0100000, 3'b101}: op = SRA;
          default:              legal = 1'b0;
        endcase
      end
      OPC_MISC_MEM: begin
        rd = f_rd; rs1 = f_rs1; imm = imm_i;
        case (f3)
          3'b000:  op = FENCE;
          3'b001:  op = FENCE_I;
          default: legal = 1'b0;
        endcase
      end
      OPC_SYSTEM: begin
        if (instr == ECALL_WORD) begin
          op = ECALL; imm = imm_z;
        end else if (instr == EBREAK_WORD) begin
          op = EBREAK; imm = imm_z;
        end else begin
          // rs1 slot carries either rs1 or the 5-bit zimm; same bit field.
          rd = f_rd; rs1 = f_rs1; imm = imm_z;
          case (f3)
            3'b001:  op = CSRRW;
            3'b010:  op = CSRRS;
            3'b011:  op = CSRRC;
            3'b101:  op = CSRRWI;
            3'b110:  op = CSRRSI;
            3'b111:  op = CSRRCI;
            default: legal = 1'b0;
          endcase
        end
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      op  = ADDI;
      rd  = '0;
      rs1 = '0;
      rs2 = '0;
      imm = instr;
    end
  end

  assign dec = '{op: op, rd: rd, rs1: rs1, rs2: rs2, imm: imm, pc: pc, illegal: !legal};

endmodule

// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: decode pipeline stage between fetch and execute.
//   clk, rst                 - core clock, synchronous active-high reset
//   in_valid/in_ready        - fetch handshake; in_ready is !skid_valid && !rst
//   in_instr, in_pc          - raw instruction word and its PC
//   flush                    - drop everything held and the current input
//   out_valid/out_ready      - execute handshake
//   out_op, out_rd/rs1/rs2,
//   out_imm, out_pc,
//   out_illegal              - registered decoded instruction
// Decode happens before the registers, so both the output register and the
// one-entry skid buffer hold decoded fields. The skid entry absorbs the one
// instruction accepted while the output is stalled, keeping in_ready a pure
// register output.
module rv32i_decode_stage
  import lib_cpu::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  if (XLEN != 32) begin : g_xlen_check
    $error("rv32i_decode_stage: only XLEN=32 is supported");
  end

  localparam DECODED OUT_RESET = '{op: LUI, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                                   imm: 32'd0, pc: RESET_PC, illegal: 1'b0};

  DECODED dec;
  DECODED out_q, out_d;
  DECODED skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_xfer;
  logic   out_free;

  rv32i_decoder u_decoder (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec)
  );

  assign in_ready = !skid_valid_q && !rst;
  assign in_xfer  = in_valid && in_ready;
  // Output register can take new content: empty, or draining this cycle.
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // With the skid full in_ready is low, so no input competes for the slot.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= OUT_RESET;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
    end
  end

  // Skid contents are only meaningful while skid_valid_q is set.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_q.op;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_imm     = out_q.imm;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;

endmodule
